// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC flow-select codes, PC FSM states and default vectors.
package cpu_pkg;

  localparam int unsigned SRC_W   = 3;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned JADDR_W = 26;

  typedef enum logic [SRC_W-1:0] {
    PC_SEQ    = 3'b000,
    PC_BRANCH = 3'b001,
    PC_JUMP   = 3'b010,
    PC_JR     = 3'b011,
    PC_ERET   = 3'b100
  } pc_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_gen_if.sv
// Control-unit to PC-generator bus: flow select and targets in, PC/EPC state out.
interface pc_gen_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic                stall;
  logic [SRC_W-1:0]    pc_src;
  logic [IMM_W-1:0]    immediate;
  logic [JADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]   reg_jump;
  logic                exc;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   next_pc;
  logic [ADDR_W-1:0]   epc;
  logic                epc_bd;
  logic                ds_pending;
  logic                addr_err;

  modport master (
    output stall, pc_src, immediate, addr, reg_jump, exc,
    input  pc, next_pc, epc, epc_bd, ds_pending, addr_err
  );

  modport slave (
    input  stall, pc_src, immediate, addr, reg_jump, exc,
    output pc, next_pc, epc, epc_bd, ds_pending, addr_err
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational candidate-target generator for every PC flow, plus jr/eret misalignment detect.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  epc,
  input  logic [ADDR_W-1:0]  reg_jump,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [JADDR_W-1:0] addr,
  input  logic [SRC_W-1:0]   pc_src,
  output logic [ADDR_W-1:0]  seq_t,
  output logic [ADDR_W-1:0]  br_t,
  output logic [ADDR_W-1:0]  jmp_t,
  output logic [ADDR_W-1:0]  jr_t,
  output logic [ADDR_W-1:0]  eret_t,
  output logic               misalign_c
);

  // Offset is formed at least as wide as the shifted immediate so the sign survives any ADDR_W.
  localparam int unsigned OFF_W = (ADDR_W > IMM_W + 2) ? ADDR_W : IMM_W + 2;

  logic [OFF_W-1:0] br_off;

  always_comb begin
    br_off     = OFF_W'($signed({immediate, 2'b00}));
    seq_t      = pc + ADDR_W'(4);
    br_t       = ADDR_W'(OFF_W'(pc) + br_off);
    jmp_t      = {pc[ADDR_W-1:28], addr, 2'b00};
    jr_t       = {reg_jump[ADDR_W-1:2], 2'b00};
    eret_t     = {epc[ADDR_W-1:2], 2'b00};
    misalign_c = 1'b0;
    case (pc_src)
      PC_JR:   misalign_c = (reg_jump[1:0] != 2'b00);
      PC_ERET: misalign_c = (epc[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator with stall hold, optional delay slot and exception entry/return.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
  parameter bit                DELAY_SLOT = 1'b0
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.slave   bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] epc_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              epc_bd_q;
  logic              addr_err_q;

  logic [ADDR_W-1:0] seq_t, br_t, jmp_t, jr_t, eret_t;
  logic              misalign_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] redir_tgt_c;
  logic [ADDR_W-1:0] adv_pc_c;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc         (pc_q),
    .epc        (epc_q),
    .reg_jump   (bus.reg_jump),
    .immediate  (bus.immediate),
    .addr       (bus.addr),
    .pc_src     (bus.pc_src),
    .seq_t      (seq_t),
    .br_t       (br_t),
    .jmp_t      (jmp_t),
    .jr_t       (jr_t),
    .eret_t     (eret_t),
    .misalign_c (misalign_c)
  );

  // Value pc loads on an advancing edge; eret is never delayed by the slot.
  always_comb begin
    redirect_c  = 1'b0;
    redir_tgt_c = seq_t;
    adv_pc_c    = seq_t;
    case (bus.pc_src)
      PC_BRANCH: begin redirect_c = 1'b1; redir_tgt_c = br_t;  end
      PC_JUMP:   begin redirect_c = 1'b1; redir_tgt_c = jmp_t; end
      PC_JR:     begin redirect_c = 1'b1; redir_tgt_c = jr_t;  end
      default:   begin redirect_c = 1'b0; redir_tgt_c = seq_t; end
    endcase
    if (state_q == ST_SLOT)
      adv_pc_c = tgt_q;
    else if (bus.pc_src == PC_ERET)
      adv_pc_c = eret_t;
    else if (redirect_c && !DELAY_SLOT)
      adv_pc_c = redir_tgt_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      epc_bd_q   <= 1'b0;
      tgt_q      <= '0;
      addr_err_q <= 1'b0;
    end else if (bus.exc) begin
      state_q    <= ST_RUN;
      pc_q       <= EXC_VEC;
      epc_q      <= (state_q == ST_SLOT) ? pc_q - ADDR_W'(4) : pc_q;
      epc_bd_q   <= (state_q == ST_SLOT);
      tgt_q      <= '0;
      addr_err_q <= 1'b0;
    end else if (bus.stall) begin
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= adv_pc_c;
      addr_err_q <= (state_q == ST_RUN) && misalign_c;
      if (state_q == ST_SLOT) begin
        state_q <= ST_RUN;
      end else if (redirect_c && DELAY_SLOT) begin
        state_q <= ST_SLOT;
        tgt_q   <= redir_tgt_c;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.next_pc    = reset ? RESET_VEC : (bus.exc ? EXC_VEC : adv_pc_c);
  assign bus.epc        = epc_q;
  assign bus.epc_bd     = epc_bd_q;
  assign bus.ds_pending = (state_q == ST_SLOT);
  assign bus.addr_err   = addr_err_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered program-counter generator; successor to the combinational next-PC logic.
- Owns the PC register and computes the next PC for sequential, branch, jump, jump-register and exception-return flow.
- Adds three features: stall hold, optional MIPS-style branch-delay-slot sequencing, and exception entry/return with an EPC register.
- Sits between the control unit and the instruction memory address port.

Parameters:
- ADDR_W, 32: PC width. Must be ≥ 29.
- RESET_VEC, 0: PC value loaded on reset, ADDR_W bits.
- EXC_VEC, 32'h0000_0080: PC value loaded on exception entry, ADDR_W bits.
- DELAY_SLOT, 0: 1 enables one architectural delay slot after every taken redirect.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC this cycle.
- pc_src  input  3  flow select: 000 seq, 001 branch, 010 jump, 011 jr, 100 eret; any other code is treated as seq.
- immediate  input  32  branch word offset, signed.
- addr  input  26  jump word index.
- reg_jump  input  ADDR_W  jr target.
- exc  input  1  exception request.
- pc  output  ADDR_W  current PC (registered).
- next_pc  output  ADDR_W  combinational preview of the value pc takes at the next advancing edge.
- epc  output  ADDR_W  saved exception PC.
- epc_bd  output  1  exception was taken while in a delay slot.
- ds_pending  output  1  high in state SLOT.
- addr_err  output  1  one-cycle pulse: jr/eret target had non-zero bits [1:0].

Behaviour:
- Reset (sync, highest priority):
  - pc=RESET_VEC, epc=0, epc_bd=0, addr_err=0, state=RUN.
  - Internal target register tgt=0.
- Target arithmetic (all results truncated to ADDR_W):
  - seq = pc+4.
  - branch = pc + (sext(immediate)<<2).
  - jump = {pc[ADDR_W-1:28], addr, 2'b00}.
  - jr = {reg_jump[ADDR_W-1:2], 2'b00}.
  - eret = {epc[ADDR_W-1:2], 2'b00}.
  - Branch and jump are computed from the redirecting instruction's own pc.
- Priority per edge: reset > exc > stall > pc_src.
- Exception entry, from any state, regardless of stall:
  - pc<=EXC_VEC, state<=RUN.
  - In RUN: epc<=pc, epc_bd<=0.
  - In SLOT: epc<=pc-4 (the branch), epc_bd<=1.
  - The pending target is discarded.
- Stall (no exc): pc, state and tgt hold; pc_src is ignored; addr_err=0.
- State RUN, advancing:
  - seq: pc<=pc+4.
  - eret: pc<=eret target immediately (never delayed), in both DELAY_SLOT modes.
  - branch/jump/jr with DELAY_SLOT=0: pc<=target.
  - branch/jump/jr with DELAY_SLOT=1: pc<=pc+4, tgt<=target, state<=SLOT.
- State SLOT, advancing: pc<=tgt, state<=RUN. pc_src is ignored, so a redirect inside a delay slot is dropped.
- SLOT across a stall: state is retained for any number of stall cycles.
- addr_err:
  - Registered pulse, high for exactly one cycle after an advancing jr/eret whose source bits [1:0]≠0.
  - The PC still advances to the aligned target.
- next_pc:
  - Equals the value pc would load on an advancing edge, ignoring stall.
  - Equals EXC_VEC when exc=1 and RESET_VEC when reset=1.
- Wrap-around: pc+4 at the top of the address space wraps to 0 with no flag.

Decomposition:
- Shared package cpu_pkg holds:
  - pc_src encodings PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR, PC_ERET;
  - state encodings ST_RUN, ST_SLOT;
  - default vector constants.
- One natural sub-module: pc_target_calc, purely combinational, producing the five candidate targets plus a misalign flag.
- The FSM, PC, EPC and tgt registers stay in pc_gen.

Test Plan:
- Reset then 3 seq cycles: pc 0→4→8→C; next_pc leads pc by one advance.
- DELAY_SLOT=0, pc=0x100, branch immediate=-2: pc=0xF8. Jump addr=0x40 at pc=0x1000_0000: pc=0x1000_0100.
- DELAY_SLOT=1, pc=0x200, jump addr=0x100: pc=0x204, ds_pending=1. Stall 3 cycles: pc holds 0x204. Next advance: pc=0x400, ds_pending=0.
- DELAY_SLOT=1 exception while ds_pending at pc=0x204: pc=EXC_VEC, epc=0x200, epc_bd=1. Then eret: pc=0x200.
- jr with reg_jump=0x303: pc=0x300; addr_err high exactly one cycle.
- exc and stall asserted together at pc=0x50: pc=EXC_VEC, epc=0x50. Reset asserted mid-SLOT: pc=RESET_VEC, ds_pending=0.
